cache_d_assoc: RTL and testbench

Parametrised write-back, write-allocate, set-associative data cache that replaces the fixed direct-mapped data cache between the MEM stage and the data-memory model. Geometry (ways, sets, words per line) is set by parameters. The block adds true-LRU replacement across 2 ways and dirty-line write-back. The processor side is unchanged: word address, single-cycle hit, `proc_stall` on miss.

---
 rtl/cache_pkg.sv | 35 +++
 rtl/cache_way.sv | 62 ++++++
 rtl/cache_d_assoc.sv | 207 ++++++++++++++++++++
 tb/tb_cache_d_assoc.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the set-associative data cache.
// Width helpers keep the derived geometry in one place for the top and the way.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_COMPARE   = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } cache_state_t;

    function automatic int off_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int sets, input int words_per_line);
        return 30 - $clog2(sets) - $clog2(words_per_line);
    endfunction

    function automatic logic [29:0] addr_tag(input logic [29:0] addr, input int off_w, input int idx_w);
        return addr >> (off_w + idx_w);
    endfunction

    function automatic logic [29:0] addr_idx(input logic [29:0] addr, input int off_w, input int idx_w);
        return (addr >> off_w) & ((30'd1 << idx_w) - 30'd1);
    endfunction

    function automatic logic [29:0] addr_off(input logic [29:0] addr, input int off_w);
        return addr & ((30'd1 << off_w) - 30'd1);
    endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the data cache: valid/dirty/tag/data arrays, tag compare,
// line read-out, single-word write port and whole-line fill port.
module cache_way
    import cache_pkg::*;
#(
    parameter int SETS   = 4,
    parameter int IDX_W  = 2,
    parameter int TAG_W  = 26,
    parameter int OFF_WS = 2,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  tag,
    input  logic [OFF_WS-1:0] off,
    input  logic              word_we,
    input  logic [31:0]       wdata,
    input  logic              fill_we,
    input  logic [LINE_W-1:0] fill_line,
    output logic              hit,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line
);

    logic [SETS-1:0]   valid_r;
    logic [SETS-1:0]   dirty_r;
    logic [TAG_W-1:0]  tag_r  [SETS];
    logic [LINE_W-1:0] data_r [SETS];

    assign rd_valid = valid_r[idx];
    assign rd_dirty = dirty_r[idx];
    assign rd_tag   = tag_r[idx];
    assign rd_line  = data_r[idx];
    assign hit      = valid_r[idx] && (tag_r[idx] == tag);

    // Status bits: reset clears them, a fill makes the line clean, a word write dirties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else if (fill_we) begin
            valid_r[idx] <= 1'b1;
            dirty_r[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_r[idx] <= 1'b1;
        end
    end

    // Tag and data storage are left unreset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_r[idx] <= fill_line;
            tag_r[idx]  <= tag;
        end else if (word_we) begin
            data_r[idx][32*off +: 32] <= wdata;
        end
    end

endmodule

// File: rtl/cache_d_assoc.sv
// Write-back, write-allocate set-associative data cache (1 or 2 ways, true LRU).
// Holds the miss FSM, LRU bits, victim selection and processor/memory muxing.
module cache_d_assoc
    import cache_pkg::*;
#(
    parameter  int WAYS           = 2,
    parameter  int SETS           = 4,
    parameter  int WORDS_PER_LINE = 4,
    localparam int OFF_W          = off_width(WORDS_PER_LINE),
    localparam int IDX_W          = idx_width(SETS),
    localparam int TAG_W          = tag_width(SETS, WORDS_PER_LINE),
    localparam int LINE_W         = 32 * WORDS_PER_LINE,
    localparam int MADDR_W        = 30 - OFF_W
) (
    input  logic               clk,
    input  logic               proc_reset_n,
    output logic               proc_stall,
    input  logic [29:0]        proc_addr,
    input  logic               proc_read,
    output logic [31:0]        proc_rdata,
    input  logic               proc_write,
    input  logic [31:0]        proc_wdata,
    output logic [MADDR_W-1:0] mem_addr,
    output logic               mem_read,
    input  logic [LINE_W-1:0]  mem_rdata,
    output logic               mem_write,
    output logic [LINE_W-1:0]  mem_wdata,
    input  logic               mem_ready
);

    // A one-word line still needs a 1-bit offset signal; it is always zero.
    localparam int OFF_WS = (OFF_W > 0) ? OFF_W : 1;

    cache_state_t       state_r, next_s;
    logic [TAG_W-1:0]   tag_s;
    logic [IDX_W-1:0]   idx_s;
    logic [OFF_WS-1:0]  off_s;
    logic [MADDR_W-1:0] maddr_s;
    logic               req_s, hit_s, hit_way_s, victim_s, victim_r;
    logic [SETS-1:0]    lru_r;
    logic [1:0]         way_hit_s, way_valid_s, way_dirty_s;
    logic [TAG_W-1:0]   way_tag_s  [2];
    logic [LINE_W-1:0]  way_line_s [2];
    logic               vic_valid_s, vic_dirty_s;
    logic [TAG_W-1:0]   vic_tag_s;
    logic [LINE_W-1:0]  vic_line_s, hit_line_s;
    logic               mem_read_r, mem_write_r;
    logic [MADDR_W-1:0] mem_addr_r;
    logic [LINE_W-1:0]  mem_wdata_r;

    assign tag_s   = TAG_W'(addr_tag(proc_addr, OFF_W, IDX_W));
    assign idx_s   = IDX_W'(addr_idx(proc_addr, OFF_W, IDX_W));
    assign off_s   = OFF_WS'(addr_off(proc_addr, OFF_W));
    assign maddr_s = MADDR_W'(proc_addr >> OFF_W);
    assign req_s   = proc_read | proc_write;

    for (genvar w = 0; w < 2; w++) begin : g_way
        if (w < WAYS) begin : g_inst
            logic word_we_s, fill_we_s;
            assign word_we_s = (state_r == ST_COMPARE) && proc_write && way_hit_s[w];
            assign fill_we_s = (state_r == ST_ALLOCATE) && mem_ready && (victim_r == 1'(w));

            cache_way #(
                .SETS   (SETS),
                .IDX_W  (IDX_W),
                .TAG_W  (TAG_W),
                .OFF_WS (OFF_WS),
                .LINE_W (LINE_W)
            ) u_way (
                .clk       (clk),
                .rst_n     (proc_reset_n),
                .idx       (idx_s),
                .tag       (tag_s),
                .off       (off_s),
                .word_we   (word_we_s),
                .wdata     (proc_wdata),
                .fill_we   (fill_we_s),
                .fill_line (mem_rdata),
                .hit       (way_hit_s[w]),
                .rd_valid  (way_valid_s[w]),
                .rd_dirty  (way_dirty_s[w]),
                .rd_tag    (way_tag_s[w]),
                .rd_line   (way_line_s[w])
            );
        end else begin : g_tie
            assign way_hit_s[w]   = 1'b0;
            assign way_valid_s[w] = 1'b0;
            assign way_dirty_s[w] = 1'b0;
            assign way_tag_s[w]   = '0;
            assign way_line_s[w]  = '0;
        end
    end

    assign hit_s       = |way_hit_s;
    assign hit_way_s   = way_hit_s[1];
    assign hit_line_s  = way_line_s[hit_way_s];
    assign vic_valid_s = way_valid_s[victim_s];
    assign vic_dirty_s = way_dirty_s[victim_s];
    assign vic_tag_s   = way_tag_s[victim_s];
    assign vic_line_s  = way_line_s[victim_s];

    // Victim choice: first invalid way (way 0 preferred), else the set's LRU way.
    always_comb begin
        victim_s = 1'b0;
        if (WAYS == 2) begin
            if (!way_valid_s[0]) begin
                victim_s = 1'b0;
            end else if (!way_valid_s[1]) begin
                victim_s = 1'b1;
            end else begin
                victim_s = lru_r[idx_s];
            end
        end else begin
            victim_s = 1'b0;
        end
    end

    // Read data is only driven on a read hit so stale lines never leak out.
    always_comb begin
        proc_rdata = 32'h0;
        if ((state_r == ST_COMPARE) && proc_read && hit_s) begin
            proc_rdata = hit_line_s[32*off_s +: 32];
        end else begin
            proc_rdata = 32'h0;
        end
    end

    // Next-state and stall decode.
    always_comb begin
        next_s     = state_r;
        proc_stall = 1'b1;
        case (state_r)
            ST_COMPARE: begin
                proc_stall = req_s & ~hit_s;
                if (req_s && !hit_s) begin
                    if (vic_valid_s && vic_dirty_s) begin
                        next_s = ST_WRITEBACK;
                    end else begin
                        next_s = ST_ALLOCATE;
                    end
                end else begin
                    next_s = ST_COMPARE;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ready) begin
                    next_s = ST_ALLOCATE;
                end else begin
                    next_s = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                if (mem_ready) begin
                    next_s = ST_COMPARE;
                end else begin
                    next_s = ST_ALLOCATE;
                end
            end
            default: begin
                next_s     = ST_COMPARE;
                proc_stall = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_r <= ST_COMPARE;
        end else begin
            state_r <= next_s;
        end
    end

    // Memory request registers, victim latch and LRU update on hits.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            victim_r    <= 1'b0;
            lru_r       <= '0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            mem_read_r  <= (next_s == ST_ALLOCATE);
            mem_write_r <= (next_s == ST_WRITEBACK);
            if ((state_r == ST_COMPARE) && req_s && !hit_s) begin
                victim_r <= victim_s;
            end
            if ((state_r == ST_COMPARE) && req_s && hit_s) begin
                lru_r[idx_s] <= ~hit_way_s;
            end
            if ((state_r == ST_COMPARE) && (next_s == ST_WRITEBACK)) begin
                mem_addr_r  <= {vic_tag_s, idx_s};
                mem_wdata_r <= vic_line_s;
            end else if (next_s == ST_ALLOCATE) begin
                mem_addr_r <= maddr_s;
            end
        end
    end

    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_cache_d_assoc.sv
// Directed self-checking bench: default 2-way cache plus a 1-way/8-set/2-word
// instance for the direct-mapped conflict case.
module tb_cache_d_assoc;

    logic         clk = 1'b0;
    logic         proc_reset_n;
    logic         proc_stall;
    logic [29:0]  proc_addr;
    logic         proc_read, proc_write;
    logic [31:0]  proc_rdata, proc_wdata;
    logic [27:0]  mem_addr;
    logic         mem_read, mem_write, mem_ready;
    logic [127:0] mem_rdata, mem_wdata;

    logic         dm_stall;
    logic [29:0]  dm_addr;
    logic         dm_read, dm_write;
    logic [31:0]  dm_rdata, dm_wdata;
    logic [28:0]  dm_mem_addr;
    logic         dm_mem_read, dm_mem_write, dm_mem_ready;
    logic [63:0]  dm_mem_rdata, dm_mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] LINE_A = {32'h33, 32'h22, 32'h11, 32'h00};
    localparam logic [127:0] LINE_B = {32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D};
    localparam logic [127:0] LINE_C = {32'h23232323, 32'h22222222, 32'h21212121, 32'h20202020};

    always #5 clk = ~clk;

    cache_d_assoc u_dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .proc_stall   (proc_stall),
        .proc_addr    (proc_addr),
        .proc_read    (proc_read),
        .proc_rdata   (proc_rdata),
        .proc_write   (proc_write),
        .proc_wdata   (proc_wdata),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready)
    );

    cache_d_assoc #(.WAYS(1), .SETS(8), .WORDS_PER_LINE(2)) u_dm (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .proc_stall   (dm_stall),
        .proc_addr    (dm_addr),
        .proc_read    (dm_read),
        .proc_rdata   (dm_rdata),
        .proc_write   (dm_write),
        .proc_wdata   (dm_wdata),
        .mem_addr     (dm_mem_addr),
        .mem_read     (dm_mem_read),
        .mem_rdata    (dm_mem_rdata),
        .mem_write    (dm_mem_write),
        .mem_wdata    (dm_mem_wdata),
        .mem_ready    (dm_mem_ready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Serve n request cycles on the main memory port; mem_ready in the last one.
    task automatic serve(input bit is_wb, input logic [27:0] exp_addr, input int n,
                         input logic [127:0] line, input logic [31:0] exp_w0);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk); #1;
            chk("req_read", 128'(mem_read), 128'(!is_wb));
            chk("req_write", 128'(mem_write), 128'(is_wb));
            chk("req_addr", 128'(mem_addr), 128'(exp_addr));
            chk("req_stall", 128'(proc_stall), 128'd1);
            if (is_wb) chk("wb_word0", 128'(mem_wdata[31:0]), 128'(exp_w0));
            mem_ready = (i == n);
            mem_rdata = line;
        end
    endtask

    task automatic main_access(input logic [29:0] addr, input bit wr, input logic [31:0] wd);
        @(negedge clk);
        proc_addr  = addr;
        proc_read  = !wr;
        proc_write = wr;
        proc_wdata = wd;
        mem_ready  = 1'b0;
        #1;
    endtask

    // One direct-mapped read miss with a 2-cycle fill, then the retried hit.
    task automatic dm_access(input logic [29:0] addr, input logic [28:0] exp_maddr, input logic [63:0] line);
        @(negedge clk);
        dm_addr = addr;
        dm_read = 1'b1;
        #1;
        chk("dm_miss_stall", 128'(dm_stall), 128'd1);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk); #1;
            chk("dm_read", 128'(dm_mem_read), 128'd1);
            chk("dm_no_write", 128'(dm_mem_write), 128'd0);
            chk("dm_addr", 128'(dm_mem_addr), 128'(exp_maddr));
            dm_mem_ready = (i == 2);
            dm_mem_rdata = line;
        end
        @(negedge clk);
        dm_mem_ready = 1'b0;
        #1;
        chk("dm_hit_stall", 128'(dm_stall), 128'd0);
        chk("dm_hit_data", 128'(dm_rdata), 128'(line[31:0]));
        chk("dm_hit_no_write", 128'(dm_mem_write), 128'd0);
    endtask

    initial begin
        proc_reset_n = 1'b0;
        proc_addr = 30'd0; proc_read = 1'b0; proc_write = 1'b0; proc_wdata = 32'd0;
        mem_ready = 1'b0; mem_rdata = 128'd0;
        dm_addr = 30'd0; dm_read = 1'b0; dm_write = 1'b0; dm_wdata = 32'd0;
        dm_mem_ready = 1'b0; dm_mem_rdata = 64'd0;
        #1;
        chk("rst_stall", 128'(proc_stall), 128'd0);
        chk("rst_rdata", 128'(proc_rdata), 128'd0);
        chk("rst_mem_read", 128'(mem_read), 128'd0);
        chk("rst_mem_write", 128'(mem_write), 128'd0);
        chk("rst_mem_addr", 128'(mem_addr), 128'd0);
        chk("rst_mem_wdata", mem_wdata, 128'd0);
        repeat (2) @(negedge clk);
        proc_reset_n = 1'b1;

        // Cold read miss of 0x10, 3-cycle fill.
        main_access(30'h10, 1'b0, 32'd0);
        chk("c1_stall_miss", 128'(proc_stall), 128'd1);
        chk("c1_no_req_yet", 128'(mem_read), 128'd0);
        serve(1'b0, 28'h4, 3, LINE_A, 32'd0);
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("c1_req_drop", 128'(mem_read), 128'd0);
        chk("c1_hit_stall", 128'(proc_stall), 128'd0);
        chk("c1_rdata", 128'(proc_rdata), 128'h00);

        // Read hit of 0x12.
        main_access(30'h12, 1'b0, 32'd0);
        chk("c2_stall", 128'(proc_stall), 128'd0);
        chk("c2_rdata", 128'(proc_rdata), 128'h22);
        chk("c2_no_read", 128'(mem_read), 128'd0);
        chk("c2_no_write", 128'(mem_write), 128'd0);

        // Write 0x00 (clean miss into way 1), read 0x10, then 0x20 evicts dirty 0x00.
        main_access(30'h00, 1'b1, 32'hDEADBEEF);
        chk("c3_wr_miss", 128'(proc_stall), 128'd1);
        serve(1'b0, 28'h0, 2, LINE_B, 32'd0);
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("c3_wr_hit", 128'(proc_stall), 128'd0);
        chk("c3_wr_rdata", 128'(proc_rdata), 128'd0);
        main_access(30'h10, 1'b0, 32'd0);
        chk("c3_rd10_stall", 128'(proc_stall), 128'd0);
        chk("c3_rd10_data", 128'(proc_rdata), 128'h00);
        main_access(30'h20, 1'b0, 32'd0);
        chk("c3_rd20_miss", 128'(proc_stall), 128'd1);
        serve(1'b1, 28'h0, 2, 128'd0, 32'hDEADBEEF);
        serve(1'b0, 28'h8, 1, LINE_C, 32'd0);
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("c3_rd20_stall", 128'(proc_stall), 128'd0);
        chk("c3_rd20_data", 128'(proc_rdata), 128'h20202020);
        main_access(30'h11, 1'b0, 32'd0);
        chk("c3_rd11_stall", 128'(proc_stall), 128'd0);
        chk("c3_rd11_data", 128'(proc_rdata), 128'h11);

        // Reset while allocating 0x30.
        main_access(30'h30, 1'b0, 32'd0);
        chk("c4_miss", 128'(proc_stall), 128'd1);
        @(negedge clk); #1;
        chk("c4_alloc_read", 128'(mem_read), 128'd1);
        chk("c4_alloc_addr", 128'(mem_addr), 128'hC);
        #1;
        proc_reset_n = 1'b0;
        proc_read = 1'b0;
        #1;
        chk("c4_read_drop", 128'(mem_read), 128'd0);
        chk("c4_addr_clr", 128'(mem_addr), 128'd0);
        chk("c4_stall_clr", 128'(proc_stall), 128'd0);
        repeat (2) @(negedge clk);
        proc_reset_n = 1'b1;

        // After reset 0x12 misses; memory stays silent for 20 cycles.
        main_access(30'h12, 1'b0, 32'd0);
        chk("c5_miss", 128'(proc_stall), 128'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            chk("c5_stall", 128'(proc_stall), 128'd1);
            chk("c5_read", 128'(mem_read), 128'd1);
            chk("c5_addr", 128'(mem_addr), 128'h4);
        end
        serve(1'b0, 28'h4, 1, LINE_A, 32'd0);
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("c5_hit_stall", 128'(proc_stall), 128'd0);
        chk("c5_hit_data", 128'(proc_rdata), 128'h22);
        proc_read = 1'b0;

        // Direct-mapped conflict: 0x00 and 0x10 share set 0.
        dm_access(30'h00, 29'h0, {32'hA1, 32'hA0});
        dm_access(30'h10, 29'h8, {32'hB1, 32'hB0});
        dm_access(30'h00, 29'h0, {32'hC1, 32'hC0});
        dm_access(30'h10, 29'h8, {32'hD1, 32'hD0});
        dm_read = 1'b0;

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
